// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM state codes, PC step and target alignment mask.
package pc_fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_HALT  = 2'd3;

    localparam int unsigned PC_STEP    = 4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_fetch_unit_redirect_reg.sv
// Pending redirect holder: remembers an aligned branch/jump target until the next PC update consumes it.
module pc_redirect_reg #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             consume,
    input  logic             discard,
    input  logic [NBITS-1:0] target,
    output logic             pending,
    output logic [NBITS-1:0] pending_target
);

    // A halt drops any redirect; a fresh capture outranks consumption of the older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending        <= 1'b0;
            pending_target <= '0;
        end else if (discard) begin
            pending <= 1'b0;
        end else if (capture) begin
            pending        <= 1'b1;
            pending_target <= target;
        end else if (consume) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch PC sequencer with branch/jump redirect, stall hold and halt.
// Define PC_FETCH_DELAY_SLOT_EN for MIPS delay-slot behaviour (default: flush wrong-path instruction).
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] PC_RESET = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_target,
    input  logic             i_halt,
    output logic             o_imem_req,
    output logic [NBITS-1:0] o_imem_addr,
    input  logic             i_imem_ack,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_pc4,
    output logic             o_valid,
    output logic             o_flush,
    output logic             o_misalign,
    output logic             o_halted
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [NBITS-1:0] pc;
    logic             active;
    logic             accept;
    logic             advance;
    logic             halt_now;
    logic             redirect_now;
    logic [NBITS-1:0] new_target;
    logic [NBITS-1:0] aligned_target;
    logic             capture;
    logic             pending;
    logic [NBITS-1:0] pending_target;
    logic             use_redirect;
    logic [NBITS-1:0] redirect_target;

    assign active       = (state == ST_FETCH) || (state == ST_HOLD);
    assign halt_now     = active && i_halt;
    assign accept       = (state == ST_FETCH) && i_imem_ack && !i_halt;
    assign advance      = accept && !i_stall;
    assign redirect_now = active && (i_branch_taken || i_jump) && !i_halt;

    // Branch wins over a simultaneous jump.
    assign new_target     = i_branch_taken ? i_branch_target : i_jump_target;
    assign aligned_target = new_target & ~NBITS'(ALIGN_MASK);

`ifdef PC_FETCH_DELAY_SLOT_EN
    assign capture         = redirect_now;
    assign use_redirect    = pending;
    assign redirect_target = pending_target;
    assign o_valid         = accept;
    assign o_flush         = 1'b0;
`else
    // Without a delay slot a redirect applies on the very ack it arrives with.
    assign capture         = redirect_now && !advance;
    assign use_redirect    = pending || redirect_now;
    assign redirect_target = redirect_now ? aligned_target : pending_target;
    assign o_valid         = accept && !use_redirect;
    assign o_flush         = redirect_now;
`endif

    pc_redirect_reg #(
        .NBITS(NBITS)
    ) u_redirect (
        .clk           (i_clk),
        .rst_n         (i_rst_n),
        .capture       (capture),
        .consume       (advance),
        .discard       (halt_now),
        .target        (aligned_target),
        .pending       (pending),
        .pending_target(pending_target)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start) state_next = ST_FETCH;
            ST_FETCH: begin
                if (i_halt)                 state_next = ST_HALT;
                else if (accept && i_stall) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_halt)       state_next = ST_HALT;
                else if (!i_stall) state_next = ST_FETCH;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            pc    <= PC_RESET;
        end else begin
            state <= state_next;
            if (advance) begin
                pc <= use_redirect ? redirect_target : pc + NBITS'(PC_STEP);
            end
        end
    end

    assign o_imem_req  = (state == ST_FETCH) && !i_stall && !i_halt;
    assign o_imem_addr = pc;
    assign o_pc        = pc;
    assign o_pc4       = pc + NBITS'(PC_STEP);
    assign o_misalign  = redirect_now && |(new_target[1:0] & ALIGN_MASK);
    assign o_halted    = (state == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, br, jmp, halt, ack;
    logic [31:0] bt, jt;
    logic        imem_req, valid, flush, misalign, halted;
    logic [31:0] imem_addr, pc, pc4;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_started, m_hold, m_halted, m_pend;
    logic [31:0] m_pc, m_ptarget;
    bit          e_acc, e_redirect, e_req, e_valid, e_flush, e_mis;
    logic [31:0] e_tgt;
    logic [100:0] e_vec, s_vec;

    always #5 clk = ~clk;

    pc_fetch_unit #(.NBITS(32), .PC_RESET(32'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
        .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
        .i_halt(halt), .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(ack),
        .o_pc(pc), .o_pc4(pc4), .o_valid(valid), .o_flush(flush),
        .o_misalign(misalign), .o_halted(halted)
    );

    task automatic model_reset();
        m_started = 0; m_hold = 0; m_halted = 0; m_pend = 0;
        m_pc = 32'h0; m_ptarget = 32'h0;
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; br = 0; jmp = 0; halt = 0; ack = 0; bt = 0; jt = 0;
    endtask

    task automatic model_eval();
        bit in_fetch;
        logic [31:0] raw;
        in_fetch   = m_started && !m_hold && !m_halted;
        e_redirect = m_started && !m_halted && (br || jmp) && !halt;
        raw        = br ? bt : jt;
        e_tgt      = {raw[31:2], 2'b00};
        e_req      = in_fetch && !stall && !halt;
        e_acc      = in_fetch && ack && !halt;
        e_mis      = e_redirect && (raw[1:0] != 2'b00);
`ifdef PC_FETCH_DELAY_SLOT_EN
        e_valid = e_acc;
        e_flush = 0;
`else
        e_valid = e_acc && !(m_pend || e_redirect);
        e_flush = e_redirect;
`endif
        e_vec = {e_req, e_valid, e_flush, e_mis, m_halted, m_pc, m_pc, m_pc + 32'd4};
    endtask

    task automatic model_advance();
        if (!m_started) begin
            m_started = start;
        end else if (!m_halted) begin
            if (halt) begin
                m_halted = 1; m_pend = 0;
            end else begin
                if (e_acc && !stall) begin
`ifdef PC_FETCH_DELAY_SLOT_EN
                    if (m_pend) begin m_pc = m_ptarget; m_pend = 0; end
                    else m_pc = m_pc + 32'd4;
                    if (e_redirect) begin m_pend = 1; m_ptarget = e_tgt; end
`else
                    if (e_redirect) m_pc = e_tgt;
                    else if (m_pend) m_pc = m_ptarget;
                    else m_pc = m_pc + 32'd4;
                    m_pend = 0;
`endif
                end else if (e_redirect) begin
                    m_pend = 1; m_ptarget = e_tgt;
                end
                if (e_acc && stall) m_hold = 1;
                else if (m_hold && !stall) m_hold = 0;
            end
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance the model at the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        s_vec = {imem_req, valid, flush, misalign, halted, imem_addr, pc, pc4};
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        logic [68:0] exp_r;
        exp_r = {5'b0, 32'h0, 32'h4};
        rst_n = 0; idle_inputs(); model_reset();
        #1;
        checks++;
        if ({imem_req, valid, flush, misalign, halted, pc, pc4} !== exp_r) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", {imem_req, valid, flush, misalign, halted, pc, pc4}, exp_r);
        end
        start = 1; ack = 1; br = 1; bt = 32'h40;
        @(posedge clk); #1;
        checks++;
        if ({imem_req, valid, flush, misalign, halted, pc, pc4} !== exp_r) begin
            errors++; $display("FAIL reset_held_clocked: got %h expected %h", {imem_req, valid, flush, misalign, halted, pc, pc4}, exp_r);
        end
        idle_inputs();
    endtask

    task automatic test_sequential();
        rst_n = 1; start = 1; ack = 1;
        run_cycle();
        checks++;
        if (s_vec !== e_vec) begin errors++; $display("FAIL seq_idle: got %h expected %h", s_vec, e_vec); end
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            checks++;
            if (s_vec[100] !== 1'b1 || s_vec[99] !== 1'b1 || s_vec[95:64] !== 32'(4 * k)) begin
                errors++; $display("FAIL seq_fetch%0d: req %b valid %b addr %h expected 1 1 %h", k, s_vec[100], s_vec[99], s_vec[95:64], 32'(4 * k));
            end
        end
        start = 0;
    endtask

    task automatic test_branch();
        jmp = 1; jt = 32'h10; ack = 1;
        run_cycle();
        jmp = 0;
`ifdef PC_FETCH_DELAY_SLOT_EN
        run_cycle();
`endif
        br = 1; bt = 32'h40;
        run_cycle();
        br = 0;
        checks++;
        if (s_vec !== e_vec) begin errors++; $display("FAIL branch_cycle: got %h expected %h", s_vec, e_vec); end
`ifdef PC_FETCH_DELAY_SLOT_EN
        checks++;
        if (s_vec[98] !== 1'b0 || s_vec[99] !== 1'b1 || s_vec[95:64] !== 32'h10) begin
            errors++; $display("FAIL branch_slot: flush %b valid %b addr %h expected 0 1 10", s_vec[98], s_vec[99], s_vec[95:64]);
        end
        run_cycle();
        checks++;
        if (s_vec[99] !== 1'b1 || s_vec[95:64] !== 32'h14) begin
            errors++; $display("FAIL branch_delay: valid %b addr %h expected 1 14", s_vec[99], s_vec[95:64]);
        end
`else
        checks++;
        if (s_vec[98] !== 1'b1 || s_vec[99] !== 1'b0) begin
            errors++; $display("FAIL branch_flush: flush %b valid %b expected 1 0", s_vec[98], s_vec[99]);
        end
`endif
        run_cycle();
        checks++;
        if (s_vec[99] !== 1'b1 || s_vec[95:64] !== 32'h40 || s_vec[98] !== 1'b0) begin
            errors++; $display("FAIL branch_target: valid %b addr %h flush %b expected 1 40 0", s_vec[99], s_vec[95:64], s_vec[98]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = m_pc;
        stall = 1; ack = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            checks++;
            if (s_vec[100] !== 1'b0 || s_vec[63:32] !== held) begin
                errors++; $display("FAIL stall_hold%0d: req %b pc %h expected 0 %h", k, s_vec[100], s_vec[63:32], held);
            end
        end
        stall = 0; ack = 1;
        run_cycle();
        checks++;
        if (s_vec[100] !== 1'b1 || s_vec[95:64] !== held || s_vec[99] !== 1'b1) begin
            errors++; $display("FAIL stall_resume: req %b addr %h valid %b expected 1 %h 1", s_vec[100], s_vec[95:64], s_vec[99], held);
        end
        stall = 1;
        run_cycle();
        stall = 0; ack = 0;
        run_cycle();
        checks++;
        if (s_vec !== e_vec) begin errors++; $display("FAIL stall_hold_state: got %h expected %h", s_vec, e_vec); end
        ack = 1;
        run_cycle();
        checks++;
        if (s_vec !== e_vec) begin errors++; $display("FAIL stall_hold_exit: got %h expected %h", s_vec, e_vec); end
    endtask

    task automatic test_priority_misalign();
        br = 1; bt = 32'h80; jmp = 1; jt = 32'hC0; ack = 1;
        run_cycle();
        br = 0; jmp = 0;
`ifdef PC_FETCH_DELAY_SLOT_EN
        run_cycle();
`endif
        run_cycle();
        checks++;
        if (s_vec[63:32] !== 32'h80) begin errors++; $display("FAIL priority_pc: got %h expected 80", s_vec[63:32]); end
        jmp = 1; jt = 32'h42;
        run_cycle();
        jmp = 0;
        checks++;
        if (s_vec[97] !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", s_vec[97]); end
`ifdef PC_FETCH_DELAY_SLOT_EN
        run_cycle();
`endif
        run_cycle();
        checks++;
        if (s_vec[63:32] !== 32'h40 || s_vec[97] !== 1'b0) begin
            errors++; $display("FAIL misalign_pc: pc %h mis %b expected 40 0", s_vec[63:32], s_vec[97]);
        end
    endtask

    task automatic test_wrap_halt();
        jmp = 1; jt = 32'hFFFF_FFFC; ack = 1;
        run_cycle();
        jmp = 0;
`ifdef PC_FETCH_DELAY_SLOT_EN
        run_cycle();
`endif
        run_cycle();
        checks++;
        if (s_vec[95:64] !== 32'hFFFF_FFFC || s_vec[31:0] !== 32'h0) begin
            errors++; $display("FAIL wrap_top: addr %h pc4 %h expected fffffffc 0", s_vec[95:64], s_vec[31:0]);
        end
        run_cycle();
        checks++;
        if (s_vec[95:64] !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", s_vec[95:64]); end
        halt = 1;
        run_cycle();
        halt = 0;
        for (int k = 0; k < 5; k++) begin
            start = 1'($urandom); ack = 1'($urandom); br = 1'($urandom); bt = $urandom;
            run_cycle();
            checks++;
            if (s_vec[100] !== 1'b0 || s_vec[96] !== 1'b1 || s_vec[99] !== 1'b0) begin
                errors++; $display("FAIL halted%0d: req %b halted %b valid %b expected 0 1 0", k, s_vec[100], s_vec[96], s_vec[99]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        rst_n = 0; model_reset(); @(posedge clk); #1;
        rst_n = 1; start = 1; ack = 1;
        repeat (3) run_cycle();
        #2;
        rst_n = 0; model_reset();
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || pc4 !== 32'h4) begin
            errors++; $display("FAIL reset_mid: req %b pc %h pc4 %h expected 0 0 4", imem_req, pc, pc4);
        end
        @(posedge clk); #1;
        rst_n = 1; start = 0;
        run_cycle();
        checks++;
        if (s_vec[100] !== 1'b0 || s_vec[99] !== 1'b0 || s_vec[63:32] !== 32'h0) begin
            errors++; $display("FAIL reset_late_ack: req %b valid %b pc %h expected 0 0 0", s_vec[100], s_vec[99], s_vec[63:32]);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        rst_n = 0; model_reset(); @(posedge clk); #1; rst_n = 1;
        for (int n = 0; n < 3000; n++) begin
            if (m_halted && ($urandom_range(0, 7) == 0)) begin
                rst_n = 0; model_reset(); idle_inputs(); @(posedge clk); #1; rst_n = 1;
            end
            start = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 1) == 0);
            br    = ($urandom_range(0, 7) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 199) == 0);
            bt = $urandom; jt = $urandom;
            run_cycle();
            checks++;
            if (s_vec !== e_vec) begin
                errors++; $display("FAIL random_cycle %0d: got %h expected %h", n, s_vec, e_vec);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0; idle_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_priority_misalign();
        test_wrap_halt();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter NBITS, default 32: width of PC, addresses and targets.
REQ-002 Parameter PC_RESET, default 0: PC value loaded on reset.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  level; leave IDLE and begin fetching.
REQ-006 i_stall  input  1  hazard stall from the decode stage; holds the PC and blocks new requests.
REQ-007 i_branch_taken  input  1  one-cycle pulse; the branch resolved as taken.
REQ-008 i_branch_target  input  NBITS  branch target from the branch adder (PC+4 + offset<<2).
REQ-009 i_jump  input  1  one-cycle pulse; unconditional jump.
REQ-010 i_jump_target  input  NBITS  jump target.
REQ-011 i_halt  input  1  halt instruction decoded.
REQ-012 o_imem_req  output  1  instruction-memory request.
REQ-013 o_imem_addr  output  NBITS  request address; equals o_pc.
REQ-014 i_imem_ack  input  1  request accepted and data returned this cycle.
REQ-015 o_pc  output  NBITS  current fetch PC.
REQ-016 o_pc4  output  NBITS  o_pc+4, feeding the branch adder.
REQ-017 o_valid  output  1  fetched instruction is valid for decode this cycle.
REQ-018 o_flush  output  1  one-cycle pulse; squash the wrong-path instruction.
REQ-019 o_misalign  output  1  one-cycle pulse; the accepted target had bits [1:0] nonzero.
REQ-020 o_halted  output  1  the unit is in HALT.

Function
REQ-021 The state machine SHALL have four states:
- IDLE -> FETCH on i_start.
- FETCH (o_imem_req=1) -> HOLD on i_imem_ack with i_stall=1.
- FETCH stays in FETCH on i_imem_ack with i_stall=0; the PC advances.
- HOLD -> FETCH when i_stall=0.
- Any state except IDLE -> HALT on i_halt; HALT is exited only by reset.
REQ-022 o_imem_req SHALL be asserted only in FETCH with i_stall=0; o_imem_addr SHALL be held stable until i_imem_ack.
REQ-023 o_valid SHALL equal i_imem_ack in FETCH, except when the returned instruction is flushed.
REQ-024 Sequential update: on ack without stall or redirect, PC <= PC+4, wrapping modulo 2^NBITS (0xFFFFFFFC -> 0x00000000).
REQ-025 Redirect priority: branch over jump when both pulse in the same cycle.
REQ-026 Redirect vs stall: a redirect SHALL be captured into a pending register even when i_stall=1 or no ack is present, and applied at the next PC update.
REQ-027 Redirect with an outstanding request: the request is never aborted; the PC loads the target after the ack.
REQ-028 Accepted targets SHALL have bits [1:0] forced to 0, with o_misalign pulsed in the cycle the redirect is captured.
REQ-029 o_pc4 SHALL be combinational from the PC register, with zero latency.
REQ-030 i_halt in the same cycle as a redirect: halt wins; the pending redirect is discarded.

Reset
REQ-031 While i_rst_n=0, regardless of clock:
- state = IDLE, PC = PC_RESET, pending redirect cleared;
- o_imem_req, o_valid, o_flush, o_misalign and o_halted = 0;
- o_pc4 = PC_RESET+4.
REQ-032 Reset asserted mid-request SHALL drop o_imem_req immediately; a late i_imem_ack is ignored.

Configuration
REQ-033 Macro PC_FETCH_DELAY_SLOT_EN.
- Defined: MIPS delay slot; the instruction after the branch is delivered with o_valid=1, o_flush is never asserted, and the target is loaded after that slot's ack.
- Undefined: a redirect pulses o_flush for one cycle, the in-flight or next returned instruction gets o_valid=0, and the target is fetched next.

Structure
REQ-034 A shared package SHALL hold the state enumeration (IDLE, FETCH, HOLD, HALT), the PC step constant 4 and the alignment mask.
REQ-035 One sub-module, pc_redirect_reg, SHALL hold the pending redirect flag and the aligned target.

Verification
REQ-036 Reset, i_start, ack every cycle -> o_imem_addr = 0x0, 0x4, 0x8; o_valid=1 each cycle.
REQ-037 PC=0x10, i_branch_taken with target 0x40 -> without the macro: o_flush pulse, next valid fetch at 0x40; with it: 0x14 valid, then 0x40.
REQ-038 i_stall=1 for 3 cycles during FETCH -> PC held, o_imem_req=0, resumes at the same address.
REQ-039 Same-cycle branch (target 0x80) and jump (target 0xC0) -> next PC 0x80; target 0x42 -> PC 0x40 with an o_misalign pulse.
REQ-040 PC=0xFFFFFFFC, ack -> PC=0x00000000; i_halt -> o_halted=1, o_imem_req=0 until reset.
REQ-041 i_rst_n low mid-request -> o_imem_req=0 the same cycle, PC=PC_RESET.
